// File: rtl/cpu_pkg.sv
// Shared definitions for the register-select datapath.
// Address width default, bit-order encodings, one-hot decode helper.
package cpu_pkg;

    localparam int AW_DEFAULT = 4;

    // Bit-order encodings for the register enable vectors.
    localparam bit REV_LSB = 1'b0;
    localparam bit REV_MSB = 1'b1;

    // True when enable bit k belongs to register address addr.
    function automatic logic onehot_hit(
        input int unsigned addr,
        input int unsigned k,
        input int unsigned nreg,
        input bit          rev
    );
        int unsigned pos;
        pos = rev ? (nreg - 1 - k) : k;
        return pos == addr;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Address to one-hot enable decoder.
// Bit order selected by REVERSE (LSB-first or MSB-first).
module onehot_decoder
    import cpu_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int NREG    = 1 << AW,
    parameter bit REVERSE = REV_LSB
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] oh
);

    // Each output bit compares its mapped index against the address.
    always_comb begin
        oh = '0;
        for (int k = 0; k < NREG; k++) begin
            oh[k] = onehot_hit(32'(addr), unsigned'(k), NREG, REVERSE);
        end
    end

endmodule

// File: rtl/reg_select_unit.sv
// Register select unit: grant-muxed address decode to registered
// read/write enables, with a busy scoreboard and RAW stall.
module reg_select_unit
    import cpu_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int NREG    = 1 << AW,
    parameter bit REVERSE = REV_LSB
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   addr_a,
    input  logic [AW-1:0]   addr_b,
    input  logic [AW-1:0]   addr_c,
    input  logic            gra,
    input  logic            grb,
    input  logic            grc,
    input  logic            rin,
    input  logic            rout,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    output logic [NREG-1:0] rin_oh,
    output logic [NREG-1:0] rout_oh,
    output logic [NREG-1:0] busy,
    output logic            stall,
    output logic            sel_err
);

    logic [1:0]      gcnt;
    logic            sel_valid;
    logic [AW-1:0]   sel_addr;
    logic [NREG-1:0] sel_oh;
    logic [NREG-1:0] wb_oh;
    logic            wb_bypass;
    logic            hazard;
    logic            issue;

    logic [NREG-1:0] rin_oh_d, rin_oh_q;
    logic [NREG-1:0] rout_oh_d, rout_oh_q;
    logic [NREG-1:0] busy_d, busy_q;
    logic            stall_d, stall_q;
    logic            sel_err_d, sel_err_q;

    onehot_decoder #(
        .AW      (AW),
        .NREG    (NREG),
        .REVERSE (REVERSE)
    ) u_sel_dec (
        .addr (sel_addr),
        .oh   (sel_oh)
    );

    onehot_decoder #(
        .AW      (AW),
        .NREG    (NREG),
        .REVERSE (REVERSE)
    ) u_wb_dec (
        .addr (wb_addr),
        .oh   (wb_oh)
    );

    // Pick the granted field; only a single grant is a usable selection.
    always_comb begin
        gcnt      = {1'b0, gra} + {1'b0, grb} + {1'b0, grc};
        sel_valid = (gcnt == 2'd1);
        sel_addr  = '0;
        if (sel_valid) begin
            unique case (1'b1)
                gra: sel_addr = addr_a;
                grb: sel_addr = addr_b;
                grc: sel_addr = addr_c;
            endcase
        end
    end

    // Hazard detection, enable generation and scoreboard update.
    always_comb begin
        wb_bypass = wb_valid & (wb_addr == sel_addr);
        hazard    = rout & sel_valid & (|(busy_q & sel_oh)) & ~wb_bypass;
        issue     = sel_valid & ~hazard;

        rin_oh_d  = (rin & issue) ? sel_oh : '0;
        rout_oh_d = (rout & issue) ? sel_oh : '0;
        stall_d   = hazard;
        sel_err_d = (rin | rout) & ~sel_valid;

        // Writeback clears first so a same-cycle new claim wins.
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d = busy_d & ~wb_oh;
        end
        if (rin & issue) begin
            busy_d = busy_d | sel_oh;
        end
    end

    // Output and scoreboard registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rin_oh_q  <= '0;
            rout_oh_q <= '0;
            busy_q    <= '0;
            stall_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            rin_oh_q  <= rin_oh_d;
            rout_oh_q <= rout_oh_d;
            busy_q    <= busy_d;
            stall_q   <= stall_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign rin_oh  = rin_oh_q;
    assign rout_oh = rout_oh_q;
    assign busy    = busy_q;
    assign stall   = stall_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_select_unit.sv
// Bench for reg_select_unit: two instances (normal and reversed
// bit order) share stimulus; a reference model feeds a queue.
module tb_reg_select_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr_a, addr_b, addr_c, wb_addr;
    logic        gra, grb, grc, rin, rout, wb_valid;

    logic [15:0] rin_oh0, rout_oh0, busy0;
    logic        stall0, sel_err0;
    logic [15:0] rin_oh1, rout_oh1, busy1;
    logic        stall1, sel_err1;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        logic [1:0][15:0] rin;
        logic [1:0][15:0] rout;
        logic [1:0][15:0] busy;
        logic [1:0]       st;
        logic [1:0]       er;
    } exp_t;

    exp_t exp_q[$];
    logic [1:0][15:0] mbusy;

    reg_select_unit #(.AW(4), .REVERSE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .rin_oh(rin_oh0), .rout_oh(rout_oh0), .busy(busy0),
        .stall(stall0), .sel_err(sel_err0)
    );

    reg_select_unit #(.AW(4), .REVERSE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .rin_oh(rin_oh1), .rout_oh(rout_oh1), .busy(busy1),
        .stall(stall1), .sel_err(sel_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mapb(input int a, input bit rev);
        return rev ? (15 - a) : a;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ga, input logic gb, input logic gc,
                        input logic [3:0] aa, input logic [3:0] ab,
                        input logic [3:0] ac, input logic ri,
                        input logic ro, input logic wv,
                        input logic [3:0] wa);
        exp_t e;
        exp_t g;
        int   cnt, sel, pos;
        bit   valid, hz, iss;
        gra = ga; grb = gb; grc = gc;
        addr_a = aa; addr_b = ab; addr_c = ac;
        rin = ri; rout = ro; wb_valid = wv; wb_addr = wa;
        cnt   = int'(ga) + int'(gb) + int'(gc);
        valid = (cnt == 1);
        sel   = ga ? int'(aa) : (gb ? int'(ab) : int'(ac));
        for (int i = 0; i < 2; i++) begin
            pos = mapb(sel, i[0]);
            hz  = ro && valid && mbusy[i][pos]
                  && !(wv && int'(wa) == sel);
            iss = valid && !hz;
            e.rin[i]  = (ri && iss) ? (16'h1 << pos) : 16'h0;
            e.rout[i] = (ro && iss) ? (16'h1 << pos) : 16'h0;
            e.st[i]   = hz;
            e.er[i]   = (ri || ro) && !valid;
            if (wv) mbusy[i][mapb(int'(wa), i[0])] = 1'b0;
            if (ri && iss) mbusy[i][pos] = 1'b1;
            e.busy[i] = mbusy[i];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("u0.rin_oh", rin_oh0, g.rin[0]);
        chk("u0.rout_oh", rout_oh0, g.rout[0]);
        chk("u0.busy", busy0, g.busy[0]);
        chk("u0.stall", 16'(stall0), 16'(g.st[0]));
        chk("u0.sel_err", 16'(sel_err0), 16'(g.er[0]));
        chk("u1.rin_oh", rin_oh1, g.rin[1]);
        chk("u1.rout_oh", rout_oh1, g.rout[1]);
        chk("u1.busy", busy1, g.busy[1]);
        chk("u1.stall", 16'(stall1), 16'(g.st[1]));
        chk("u1.sel_err", 16'(sel_err1), 16'(g.er[1]));
        chk("u0.onehot", 16'($onehot0(rin_oh0) && $onehot0(rout_oh0)),
            16'h1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rin_oh"}, rin_oh0 | rin_oh1, 16'h0);
        chk({tag, ".rout_oh"}, rout_oh0 | rout_oh1, 16'h0);
        chk({tag, ".busy"}, busy0 | busy1, 16'h0);
        chk({tag, ".stat"}, 16'({stall0, sel_err0, stall1, sel_err1}),
            16'h0);
    endtask

    initial begin
        mbusy = '0;
        rst_n = 1'b0;
        {gra, grb, grc, rin, rout, wb_valid} = '0;
        {addr_a, addr_b, addr_c, wb_addr} = '0;
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Write-select of register 0, LSB-first mapping.
        step(1, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
        chk("r031.rin_oh", rin_oh0, 16'h0001);
        chk("r031.busy", busy0, 16'h0001);

        // Read register 15 on the reversed instance.
        step(0, 1, 0, 0, 4'hF, 0, 0, 1, 0, 0);
        chk("r032.rout_oh", rout_oh1, 16'h0001);
        chk("r032.stall", 16'(stall1), 16'h0);

        // RAW hazard on register 5, then writeback bypass.
        step(0, 0, 1, 0, 0, 4'h5, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 4'h5, 0, 1, 0, 0);
        chk("r033.stall", 16'(stall0), 16'h1);
        chk("r033.rout_oh", rout_oh0, 16'h0);
        step(0, 0, 1, 0, 0, 4'h5, 0, 1, 1, 4'h5);
        chk("r033b.rout_oh", rout_oh0, 16'h0020);
        chk("r033b.stall", 16'(stall0), 16'h0);
        chk("r033b.busy5", busy0 & 16'h0020, 16'h0);

        // Two grants: selection error for one cycle only.
        step(1, 1, 0, 4'h2, 4'h4, 0, 1, 0, 0, 0);
        chk("r034.sel_err", 16'(sel_err0), 16'h1);
        chk("r034.rin_oh", rin_oh0, 16'h0);
        chk("r034.busy", busy0, 16'h0001);
        idle();
        chk("r034.pulse", 16'(sel_err0), 16'h0);

        // Same-cycle claim and release of register 3: claim wins.
        step(1, 0, 0, 4'h3, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h3, 0, 0, 1, 0, 1, 4'h3);
        chk("r035.busy3", busy0 & 16'h0008, 16'h0008);

        // Writeback to an idle register is ignored.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h9);
        // rin and rout together on register 7.
        step(1, 0, 0, 4'h7, 0, 0, 1, 1, 0, 0);
        chk("r018.same", rin_oh0 ^ rout_oh0, 16'h0);
        // No grant with a request.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Fill registers 0..7, then reset between edges.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 4'(i), 0, 0, 1, 0, 0, 0);
        end
        chk("r036.pre", busy0, 16'h00FF);
        #2;
        rst_n = 1'b0;
        mbusy = '0;
        #1;
        chk_zero("r036");
        #1;
        rst_n = 1'b1;

        // First decode after release.
        step(0, 1, 0, 0, 4'hA, 0, 1, 0, 0, 0);
        chk("r027.rin_oh", rin_oh0, 16'h0400);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
